// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl: serves single-byte lookups by issuing SPI NOR READ (0x03) transactions in mode 0
// clk, rst        : system clock, synchronous active-high reset
// fd_valid        : request level from the initiator
// fd_address      : 24-bit byte address of the request
// fd, fd_ready    : returned byte and its valid flag (level handshake)
// spi_cs_n        : flash chip select, active low
// spi_sck         : SPI clock, idles low
// spi_mosi        : command/address out
// spi_miso        : data in
module flash_read_ctrl #(
   parameter int         CLK_DIV  = 2,
   parameter logic [7:0] READ_CMD = 8'h03
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fd_valid,
   input  logic [23:0] fd_address,
   output logic [7:0]  fd,
   output logic        fd_ready,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);
   typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;
   localparam logic [7:0] DIV    = 8'(CLK_DIV);
   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
   state_t      state_q;
   logic [23:0] addr_q;
   logic [39:0] tx_q;
   logic [7:0]  rx_q;
   logic [7:0]  cnt_q;
   logic [7:0]  gap_q;
   logic [5:0]  bit_q;
   logic [7:0]  fd_q;
   logic        rdy_q;
   logic        cs_n_q;
   logic        sck_q;
   logic        mosi_q;
   assign fd       = fd_q;
   assign fd_ready = rdy_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cnt_q   <= '0;
         gap_q   <= DIV_M1;
         bit_q   <= '0;
         fd_q    <= '0;
         rdy_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         // gap_q saturates at DIV_M1 once CS has been high for CLK_DIV cycles
         if (cs_n_q && gap_q != DIV_M1) gap_q <= gap_q + 8'd1;
         case (state_q)
            IDLE: if (fd_valid && gap_q == DIV_M1) begin
               addr_q  <= fd_address;
               tx_q    <= {READ_CMD, fd_address, 8'h00};
               mosi_q  <= READ_CMD[7];
               cs_n_q  <= 1'b0;
               cnt_q   <= '0;
               bit_q   <= '0;
               state_q <= CS_SETUP;
            end
            CS_SETUP: if (cnt_q == DIV_M1) begin
               cnt_q   <= '0;
               state_q <= SHIFT;
            end else cnt_q <= cnt_q + 8'd1;
            SHIFT: if (cnt_q == DIV_M1) begin
               cnt_q <= '0;
               sck_q <= ~sck_q;
               // rx keeps only the last 8 samples, i.e. the data byte after the address
               if (!sck_q) rx_q <= {rx_q[6:0], spi_miso};
               else begin
                  tx_q   <= {tx_q[38:0], 1'b0};
                  mosi_q <= tx_q[38];
                  bit_q  <= bit_q + 6'd1;
                  if (bit_q == 6'd39) state_q <= CS_HOLD;
               end
            end else cnt_q <= cnt_q + 8'd1;
            CS_HOLD: if (cnt_q == DIV) begin
               fd_q    <= rx_q;
               rdy_q   <= 1'b1;
               cs_n_q  <= 1'b1;
               gap_q   <= '0;
               state_q <= DONE;
            end else cnt_q <= cnt_q + 8'd1;
            DONE: if (!fd_valid || fd_address != addr_q) begin
               rdy_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_flash_read_ctrl.sv
// tb_flash_read_ctrl: randomized checks of flash_read_ctrl at CLK_DIV=2 and CLK_DIV=1 against a flash model
module tb_flash_read_ctrl;
   logic        clk = 1'b0;
   logic        rst [2];
   logic        fd_valid [2];
   logic [23:0] fd_address [2];
   logic [7:0]  fd [2];
   logic        fd_ready [2];
   logic        cs_n [2];
   logic        sck [2];
   logic        mosi [2];
   logic        miso [2] = '{1'b0, 1'b0};
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          cs_fall [2] = '{0, 0};
   int          cs_rise [2] = '{0, 0};
   int          cs_falls [2] = '{0, 0};
   int          rises [2] = '{0, 0};
   int          sck_bad [2] = '{0, 0};
   int          gap_viol [2] = '{0, 0};
   logic        rst_seen [2] = '{1'b1, 1'b1};
   logic        prev_cs [2] = '{1'b1, 1'b1};
   logic        prev_sck [2] = '{1'b0, 1'b0};
   logic [39:0] cap [2] = '{40'h0, 40'h0};
   logic [7:0]  dat [2] = '{8'h0, 8'h0};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   flash_read_ctrl #(.CLK_DIV(2)) dut0 (
      .clk(clk), .rst(rst[0]), .fd_valid(fd_valid[0]), .fd_address(fd_address[0]), .fd(fd[0]),
      .fd_ready(fd_ready[0]), .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
   );
   flash_read_ctrl #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst[1]), .fd_valid(fd_valid[1]), .fd_address(fd_address[1]), .fd(fd[1]),
      .fd_ready(fd_ready[1]), .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
   );
   function automatic int div(input int g);
      return g == 0 ? 2 : 1;
   endfunction
   // flash contents: two fixed bytes for the named addresses, a hash everywhere else
   function automatic logic [7:0] ref_byte(input logic [23:0] a);
      if (a == 24'h123456) return 8'hA5;
      if (a == 24'h0000FF) return 8'h3C;
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction
   // SPI NOR model plus bus monitor; miso gets junk after each rising SCK so a wrong sampling edge shows up
   always @(posedge clk) begin
      #1;
      for (int g = 0; g < 2; g++) begin
         if (sck[g] && cs_n[g]) sck_bad[g] <= sck_bad[g] + 1;
         if (prev_cs[g] && !cs_n[g]) begin
            cs_fall[g]  <= cyc;
            cs_falls[g] <= cs_falls[g] + 1;
            rises[g]    <= 0;
            rst_seen[g] <= 1'b0;
            if (!rst_seen[g] && cyc - cs_rise[g] < div(g)) gap_viol[g] <= gap_viol[g] + 1;
         end else if (rst[g]) rst_seen[g] <= 1'b1;
         if (!prev_cs[g] && cs_n[g]) cs_rise[g] <= cyc;
         if (!cs_n[g] && sck[g] && !prev_sck[g]) begin
            cap[g]   <= {cap[g][38:0], mosi[g]};
            rises[g] <= rises[g] + 1;
            miso[g]  <= 1'($urandom);
            if (rises[g] == 31) dat[g] <= ref_byte({cap[g][22:0], mosi[g]});
         end
         if (!cs_n[g] && !sck[g] && prev_sck[g] && rises[g] >= 32 && rises[g] < 40) miso[g] <= dat[g][39 - rises[g]];
         prev_cs[g]  <= cs_n[g];
         prev_sck[g] <= sck[g];
      end
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_ready(input int g);
      bit ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         ok = fd_ready[g];
      end
      check("ready_timeout", ok, 1);
   endtask
   task automatic wait_rises(input int g, input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge clk);
         ok = (rises[g] == n);
      end
      check("rise_timeout", ok, 1);
   endtask
   task automatic finish_read(input int g, input logic [23:0] a);
      wait_ready(g);
      check("latency", cyc - cs_fall[g], 1 + 82 * div(g));
      check("data", fd[g], ref_byte(a));
      check("mosi_stream", cap[g], {8'h03, a, 8'h00});
      check("sck_rises", rises[g], 40);
      check("cs_released", cs_n[g], 1);
   endtask
   task automatic check_reset(input int g);
      check("reset_out", {fd[g], fd_ready[g], cs_n[g], sck[g], mosi[g]}, {8'h00, 4'b0100});
   endtask
   task automatic random_reads(input int g, input int n);
      logic [23:0] a;
      for (int i = 0; i < n; i++) begin
         a = 24'($urandom);
         if (a == fd_address[g]) a = ~a;
         if ($urandom_range(1, 0) == 1) begin
            @(negedge clk);
            fd_valid[g] = 1'b0;
            repeat ($urandom_range(4, 1)) @(negedge clk);
         end
         @(negedge clk);
         fd_valid[g]   = 1'b1;
         fd_address[g] = a;
         finish_read(g, a);
         repeat ($urandom_range(10, 0)) @(negedge clk);
      end
   endtask
   initial begin
      int req;
      int n0;
      for (int g = 0; g < 2; g++) begin
         rst[g]        = 1'b1;
         fd_valid[g]   = 1'b0;
         fd_address[g] = '0;
      end
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      fd_valid[0]   = 1'b1;
      fd_address[0] = 24'h123456;
      @(negedge clk);
      check("rst_wins", cs_n[0], 1);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      req = cyc + 1;
      finish_read(0, 24'h123456);
      check("start_cycle", cs_fall[0], req);
      n0 = cs_falls[0];
      for (int i = 0; i < 10; i++) begin
         repeat (50) @(negedge clk);
         check("hold", {fd_ready[0], fd[0]}, {1'b1, 8'hA5});
      end
      check("no_reread", cs_falls[0], n0);
      fd_address[0] = 24'h0000FF;
      req = cyc + 1;
      @(negedge clk);
      check("ready_drop", fd_ready[0], 0);
      finish_read(0, 24'h0000FF);
      check("restart_cycle", cs_fall[0], req + 1);
      @(negedge clk);
      fd_address[0] = 24'hABCDEF;
      wait_rises(0, 20);
      rst[0] = 1'b1;
      @(negedge clk);
      check_reset(0);
      rst[0] = 1'b0;
      req = cyc + 1;
      finish_read(0, 24'hABCDEF);
      check("post_reset_start", cs_fall[0], req);
      @(negedge clk);
      fd_address[0] = 24'h55AA33;
      wait_rises(0, 10);
      fd_address[0] = 24'h0F0F0F;
      wait_ready(0);
      check("orig_data", fd[0], ref_byte(24'h55AA33));
      check("orig_stream", cap[0], {8'h03, 24'h55AA33, 8'h00});
      @(negedge clk);
      check("stale_pulse", fd_ready[0], 0);
      finish_read(0, 24'h0F0F0F);
      @(negedge clk);
      fd_address[0] = 24'h777777;
      wait_rises(0, 5);
      fd_valid[0] = 1'b0;
      wait_ready(0);
      check("drop_data", fd[0], ref_byte(24'h777777));
      @(negedge clk);
      check("drop_pulse", fd_ready[0], 0);
      random_reads(0, 5);
      @(negedge clk);
      fd_valid[1]   = 1'b1;
      fd_address[1] = 24'h123456;
      req = cyc + 1;
      finish_read(1, 24'h123456);
      check("div1_start", cs_fall[1], req);
      random_reads(1, 6);
      repeat (4) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("sck_while_cs_high", sck_bad[g], 0);
         check("cs_gap", gap_viol[g], 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
- Responder side of the flash-data lookup interface: accepts a 24-bit byte address with fd_valid and returns one byte on fd with fd_ready.
- Drives an external SPI NOR flash using the standard READ command (0x03 + 24-bit address, then 8 data bits), SPI mode 0.
- Sits between the exposure-control FSM's LUT lookup request and the board flash pins.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period; legal range 1..255.
- READ_CMD, 8'h03, SPI opcode shifted out first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fd_valid  in  1  read request level from initiator.
- fd_address  in  24  byte address of the request.
- fd  out  8  returned data byte.
- fd_ready  out  1  fd holds data for the current request.
- spi_cs_n  out  1  flash chip select, active low.
- spi_sck  out  1  SPI clock; idles low.
- spi_mosi  out  1  command/address to flash.
- spi_miso  in  1  data from flash.

Behaviour:
- Reset (rst=1 at a clk edge), outputs after that edge:
  - fd=0, fd_ready=0, spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - State=IDLE; address latch cleared; gap counter loaded to "satisfied".
  - Applies mid-transaction too: CS releases on the next edge and no partial byte is ever flagged ready.
- States: IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
- IDLE:
  - When fd_valid=1 and the CS-high gap of >=CLK_DIV cycles is satisfied, latch fd_address into addr_q and load the 40-bit shift register {READ_CMD, fd_address, 8'h00}. Next state is CS_SETUP.
  - fd_address changes after latching are ignored until DONE.
- CS_SETUP:
  - spi_cs_n=0, spi_sck=0, spi_mosi=shift[39]; lasts CLK_DIV cycles, then SHIFT.
- SHIFT:
  - 80 SCK half-periods, each CLK_DIV cycles; the first half-period raises SCK.
  - Rising SCK edge: sample spi_miso into rx[0] while shifting rx left. Only bits 33..40 (the 8 post-address bits) are kept.
  - Falling SCK edge: shift the TX register left; spi_mosi=new shift[39].
  - 6-bit bit counter 0..39; after the 40th falling edge go to CS_HOLD with SCK low.
- CS_HOLD:
  - spi_cs_n=0, sck=0 for CLK_DIV cycles, then DONE.
  - On entry to DONE: fd<=rx byte, fd_ready<=1, spi_cs_n<=1.
- Latency: fd_ready first high exactly 1+82*CLK_DIV cycles after the edge sampling fd_valid in IDLE (165 cycles at CLK_DIV=2).
- DONE (level handshake):
  - fd_ready stays 1 and fd stays stable while fd_valid=1 and fd_address==addr_q. No re-read occurs.
  - When fd_valid=0 or fd_address!=addr_q: fd_ready<=0 on that edge and go to IDLE.
  - fd keeps its last value until overwritten.
  - If fd_valid=1 with a new address, the next read starts as soon as the CS-high gap (>=CLK_DIV cycles since CS rose) is met.
- fd_valid dropping mid-transaction: the transaction completes to DONE; DONE then immediately exits since fd_valid=0, and fd_ready pulses at most 1 cycle. Initiators must ignore it while fd_valid=0.
- Bit order: MSB first for command, address and data.
- Simultaneous rst and fd_valid: reset wins; no transaction starts.
- spi_sck never toggles while spi_cs_n=1.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Basic read, CLK_DIV=2: fd_valid=1, fd_address=24'h12_34_56, flash model returns 8'hA5.
  - MOSI stream 03 12 34 56; 40 SCK rising edges.
  - fd_ready rises 165 cycles later with fd=8'hA5; CS high same edge.
- Hold request: keep fd_valid=1 and the same address for 500 cycles after ready.
  - fd_ready stays 1, fd=8'hA5, no further CS assertion.
- Address change: in DONE, switch to 24'h00_00_FF, model byte 8'h3C.
  - fd_ready=0 on next edge; CS high for >=2 cycles.
  - New transaction: MOSI 03 00 00 FF; fd=8'h3C, fd_ready=1 after 165 cycles.
- Reset mid-SHIFT: assert rst for 1 cycle at bit 20.
  - Next edge: spi_cs_n=1, sck=0, fd=0, fd_ready=0.
  - With fd_valid still 1, a fresh full transaction follows.
- Mid-transaction address change: alter fd_address during SHIFT.
  - MOSI still carries the original address; after DONE, fd_ready drops and a re-read of the new address starts.
- CLK_DIV=1: same read as the first scenario.
  - fd_ready at 83 cycles.
  - SCK period 2 clk cycles; MISO sampled only on rising SCK.
